// File: rtl/conv_win_pkg.sv
// rtl/conv_win_pkg.sv - shared types and constants for the 3x3 sliding-window generator
//
// Contents:
//   pix_word_t  : one pixel word, 8 unsigned 8-bit channels (channel k in [k*8 +: 8])
//   win_t       : 3x3 window of pixel words, [row][col], [0][0] = oldest row/column
//   hist_t      : column-history entry, columns c-2/c-1 for window rows 0..2
//   win_state_e : controller states
package conv_win_pkg;

  localparam int PE_LANES = 8;
  localparam int PIX_W    = 8 * PE_LANES;

  typedef logic [PIX_W-1:0] pix_word_t;
  typedef pix_word_t [0:2][0:2] win_t;

  // Entry layout: index row*2 + 0 holds column c-2, row*2 + 1 holds column c-1.
  typedef pix_word_t [0:5] hist_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_e;

  function automatic int hist_idx(input int row, input int col_old);
    return row * 2 + col_old;
  endfunction

endpackage

// File: rtl/conv_win_ram.sv
// rtl/conv_win_ram.sv - simple dual-port RAM, read-first, registered read
//
// Ports:
//   clk   : clock
//   we    : write enable, writes wdata to waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable, registers mem[raddr] into rdata
//   raddr : read address
//   rdata : read data, valid the cycle after re
// A read and write to the same address in one cycle returns the old contents.
module conv_win_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 3x3 sliding-window generator over channel-grouped raster pixels
//
// Optional feature macro: CONV_WIN_ERR_EN (adds sticky cfg_err output).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, latches cfg_* while IDLE
//   cfg_width/height  : image size W, H (both >= 3)
//   cfg_cg            : channel groups CG (1..MAX_CG)
//   in_valid/in_ready : input handshake, in_ready high only in RUN
//   in_data           : pixel word for (row r, column c, group g), raster order, g fastest
//   win_valid         : one-cycle window strobe, 2 cycles after the accept that completes it
//   win_last_channel  : window belongs to group CG-1
//   win_pixels        : window [row][col], rows r-2..r, columns c-2..c of group g
//   frame_done        : pulses with the final window of the frame
//   busy              : state != IDLE
//   cfg_err           : (CONV_WIN_ERR_EN only) sticky bad-start flag, cleared by rst
module conv_window_gen
  import conv_win_pkg::*;
#(
  parameter int MAX_WIDTH  = 416,
  parameter int MAX_HEIGHT = 416,
  parameter int MAX_CG     = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
  input  logic [$clog2(MAX_CG+1)-1:0]     cfg_cg,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  pix_word_t                       in_data,
  output logic                            win_valid,
  output logic                            win_last_channel,
  output win_t                            win_pixels,
  output logic                            frame_done,
  output logic                            busy
`ifdef CONV_WIN_ERR_EN
  ,
  output logic                            cfg_err
`endif
);

  localparam int WW       = $clog2(MAX_WIDTH + 1);
  localparam int HW       = $clog2(MAX_HEIGHT + 1);
  localparam int CGW      = $clog2(MAX_CG + 1);
  localparam int LB_DEPTH = MAX_WIDTH * MAX_CG;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int HIST_AW  = (MAX_CG > 1) ? $clog2(MAX_CG) : 1;

  // ---------------------------------------------------------------------------
  // Control: state, latched configuration, position counters
  // ---------------------------------------------------------------------------
  win_state_e       state;
  logic [WW-1:0]    w_q;
  logic [HW-1:0]    h_q;
  logic [CGW-1:0]   cg_q;
  logic [CGW-1:0]   g;
  logic [WW-1:0]    c;
  logic [HW-1:0]    r;
  // Line-buffer address c*CG+g; raster order makes it a plain per-row counter.
  logic [LB_AW-1:0] addr;

  logic cfg_ok;
  logic accept;
  logic last_g;
  logic last_c;
  logic last_r;

  assign cfg_ok = (cfg_width  >= WW'(3))  && (cfg_width  <= WW'(MAX_WIDTH))  &&
                  (cfg_height >= HW'(3))  && (cfg_height <= HW'(MAX_HEIGHT)) &&
                  (cfg_cg     >= CGW'(1)) && (cfg_cg     <= CGW'(MAX_CG));

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  assign last_g = (g == cg_q - CGW'(1));
  assign last_c = (c == w_q  - WW'(1));
  assign last_r = (r == h_q  - HW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
      cg_q  <= '0;
      g     <= '0;
      c     <= '0;
      r     <= '0;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            w_q   <= cfg_width;
            h_q   <= cfg_height;
            cg_q  <= cfg_cg;
            g     <= '0;
            c     <= '0;
            r     <= '0;
            addr  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_g) begin
              g <= '0;
              if (last_c) begin
                c    <= '0;
                addr <= '0;
                r    <= r + HW'(1);
              end else begin
                c    <= c + WW'(1);
                addr <= addr + LB_AW'(1);
              end
            end else begin
              g    <= g + CGW'(1);
              addr <= addr + LB_AW'(1);
            end
            if (last_g && last_c && last_r) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // frame_done marks the last window leaving the pipeline.
          if (frame_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_WIN_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if (start && ((state != IDLE) || !cfg_ok)) begin
      cfg_err <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: word registered alongside the RAM reads it launched
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  pix_word_t        s1_data;
  logic [CGW-1:0]   s1_g;
  logic [LB_AW-1:0] s1_addr;
  logic             s1_emit;
  logic             s1_lastch;
  logic             s1_last;
  logic             s1_fwd;
  hist_t            fwd_q;

  pix_word_t lb1_rdata;
  pix_word_t lb2_rdata;
  hist_t     hist_rdata;
  hist_t     hist_cur;
  hist_t     hist_wdata;
  pix_word_t col_new [0:2];
  win_t      win_next;

  // Consecutive accepts of the same group (CG=1) read the history entry in the
  // same cycle the previous word writes it; read-first RAM returns the stale
  // entry, so the just-written value is forwarded instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_fwd   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_fwd   <= accept && s1_valid && (g == s1_g);
    end
  end

  always_ff @(posedge clk) begin
    s1_data   <= in_data;
    s1_g      <= g;
    s1_addr   <= addr;
    s1_emit   <= (r >= HW'(2)) && (c >= WW'(2));
    s1_lastch <= last_g;
    s1_last   <= last_g && last_c && last_r;
    fwd_q     <= hist_wdata;
  end

  // Row r-1 buffer: new word in, previous row's word out (read-first).
  conv_win_ram #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (LB_DEPTH)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .waddr (addr),
    .wdata (in_data),
    .re    (accept),
    .raddr (addr),
    .rdata (lb1_rdata)
  );

  // Row r-2 buffer: takes what row r-1 held one cycle later.
  conv_win_ram #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (LB_DEPTH)
  ) u_lb2 (
    .clk   (clk),
    .we    (s1_valid),
    .waddr (s1_addr),
    .wdata (lb1_rdata),
    .re    (accept),
    .raddr (addr),
    .rdata (lb2_rdata)
  );

  // Per-group history of columns c-1 and c-2 for all three window rows.
  conv_win_ram #(
    .WIDTH ($bits(hist_t)),
    .DEPTH (MAX_CG)
  ) u_hist (
    .clk   (clk),
    .we    (s1_valid),
    .waddr (s1_g[HIST_AW-1:0]),
    .wdata (hist_wdata),
    .re    (accept),
    .raddr (g[HIST_AW-1:0]),
    .rdata (hist_rdata)
  );

  always_comb begin
    hist_cur   = s1_fwd ? fwd_q : hist_rdata;
    col_new[0] = lb2_rdata;
    col_new[1] = lb1_rdata;
    col_new[2] = s1_data;
    hist_wdata = '0;
    win_next   = '0;
    for (int i = 0; i < 3; i++) begin
      hist_wdata[hist_idx(i, 0)] = hist_cur[hist_idx(i, 1)];
      hist_wdata[hist_idx(i, 1)] = col_new[i];
      win_next[i][0]             = hist_cur[hist_idx(i, 0)];
      win_next[i][1]             = hist_cur[hist_idx(i, 1)];
      win_next[i][2]             = col_new[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered window outputs; r<2 or c<2 never emits, which also
  // hides whatever the RAMs held from an earlier or aborted frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid        <= 1'b0;
      win_last_channel <= 1'b0;
      win_pixels       <= '0;
      frame_done       <= 1'b0;
    end else begin
      win_valid  <= s1_valid && s1_emit;
      frame_done <= s1_valid && s1_last;
      if (s1_valid && s1_emit) begin
        win_pixels       <= win_next;
        win_last_channel <= s1_lastch;
      end
    end
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that feeds `conv_pe`. It accepts a raster-ordered stream of 64-bit pixel words, each holding 8 unsigned 8-bit channels. It emits one 3×3 window per input word once two full rows and two columns are buffered, using valid (unpadded) convolution with stride 1. Input channels arrive as groups of 8 per pixel; the block repeats each window position once per channel group and flags the final group with `win_last_channel`, matching the PE accumulate/flush protocol.

## Interface
- `MAX_WIDTH`, 416, maximum image width in pixels
- `MAX_HEIGHT`, 416, maximum image height in pixels
- `MAX_CG`, 128, maximum input channel groups (8 channels each)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse; latches configuration in IDLE
- `cfg_width`  in  $clog2(MAX_WIDTH+1)  image width W
- `cfg_height`  in  $clog2(MAX_HEIGHT+1)  image height H
- `cfg_cg`  in  $clog2(MAX_CG+1)  channel groups CG
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  high only in RUN
- `in_data`  in  64  channel k in bits [k*8 +: 8], unsigned
- `win_valid`  out  1  window valid (single-cycle, no backpressure)
- `win_last_channel`  out  1  window belongs to group CG-1
- `win_pixels`  out  64 × [0:2][0:2]  [row][col]; [0][0] = oldest row, oldest column
- `frame_done`  out  1  one-cycle pulse with the final window of the frame
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, RUN, and FLUSH.
- **IDLE → RUN:** on `start` with W≥3, H≥3, and 1≤CG≤MAX_CG. The block latches the configuration and clears counters `g`, `c`, and `r`.
- **Invalid config:** `start` is ignored and the block stays in IDLE.
- **`start` outside IDLE:** ignored.
- **RUN:** a word is accepted when `in_valid & in_ready`. Counters increment as g → c → r, with wrap at CG-1 and W-1.
- **RUN → FLUSH:** on acceptance of (H-1, W-1, CG-1). `in_ready` drops the next cycle.
- **FLUSH → IDLE:** after the pipeline drains (2 cycles), coincident with `frame_done`.
- **Line buffers:** two line buffers (row r-1, row r-2), addressed `c*CG+g`, read-before-write. An accepted word shifts into row r-1 and the old row r-1 content shifts into row r-2.
- **Column history:** per-group column history, depth MAX_CG, holds columns c-1 and c-2 of all three rows for group g.
- **Window emission:** accepted word (r,c,g) with r≥2 and c≥2 produces a window over rows r-2..r and columns c-2..c of group g.
  - `win_last_channel` = (g == CG-1).
  - Words with r<2 or c<2 produce no window, so stale RAM contents are never visible.
- **Output count:** windows per frame = (H-2)·(W-2)·CG.
- **Data path:** no arithmetic on data; words are passed bit-exact.

## Timing
- Latency is 2 cycles, fixed: an input accepted at cycle t produces `win_valid` at t+2.
- Input gaps (`in_valid` low) produce output gaps. Output order equals input order.
- `in_ready` is combinational from state only, never from `in_valid`.
- `frame_done` is asserted in the same cycle as the last `win_valid`. `busy` falls the following cycle. A new `start` is accepted from that cycle on.
- **Reset values:** `in_ready` 0, `win_valid` 0, `win_last_channel` 0, `win_pixels` 0, `frame_done` 0, `busy` 0, state IDLE, counters 0.
- **Reset mid-frame:** the block aborts immediately and emits no further windows. RAM contents are not cleared because they are masked by the r/c<2 rule.

## Configuration
- `CONV_WIN_ERR_EN` defined: adds output `cfg_err` (1 bit, reset 0).
  - Set sticky on `start` with invalid configuration, or on `start` outside IDLE.
  - Cleared only by `rst`.
- `CONV_WIN_ERR_EN` undefined: the port is absent and these events are silently ignored.

## Structure
- Package `conv_win_pkg` holds:
  - `pix_word_t` (logic [63:0]) and `win_t` (pix_word_t [0:2][0:2]).
  - Constant `PE_LANES` = 8.
  - Enum `win_state_e` {IDLE, RUN, FLUSH}.
- Sub-module `conv_win_ram` is a simple dual-port, read-first, registered-read RAM, parameterised by width and depth. It is instantiated for both line buffers and for column history (3 rows × 2 columns packed per entry).

## Test plan
- **Basic 4×4 frame:** W=H=4, CG=1, byte0 = r*4+c, other bytes 0, in_valid continuous.
  - Exactly 4 windows.
  - First window rows {0,1,2},{4,5,6},{8,9,10} at 2 cycles after accept of value 10.
  - `frame_done` coincides with window centred on 10→15, i.e. rows {5,6,7},{9,10,11},{13,14,15}.
- **Channel groups:** W=H=3, CG=2, word = {r,c,g} encoded in byte0.
  - 2 windows, `win_last_channel` 0 then 1.
  - Each window is built only from words of the matching g.
- **Input gaps:** random in_valid with 50% duty on the 5×5, CG=3 frame.
  - 27 windows, identical content and order to the continuous-valid run.
  - No `win_valid` without a matching accept.
- **Reset mid-frame:** assert rst after 10 accepts, then start a 3×3, CG=1 frame.
  - All outputs return to 0 the cycle after rst.
  - The new frame yields exactly 1 correct window, with no stale data.
- **Invalid config:** start with W=2 (and separately CG=0).
  - `busy` stays 0 and `in_ready` stays 0.
  - With `CONV_WIN_ERR_EN`, `cfg_err`=1 the following cycle.
- **Back-to-back frames:** start in the cycle after `frame_done`.
  - Second frame accepted; `in_ready` rises the cycle after that start.
  - Window count correct for both frames.
